// File: rtl/mult_share_arbiter_taint.sv
// Round-robin front end that shares one sequential multiplier between two requesters, with taint tracking.
// Latency: grant on the sampling edge, start pulse the next cycle, ack one cycle after done is sampled; a held request only waits, it is never dropped.
module mult_share_arbiter_taint #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic               req0_t,
    input  logic               req1_t,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a0_t,
    input  logic [WIDTH-1:0]   b0_t,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    input  logic [WIDTH-1:0]   a1_t,
    input  logic [WIDTH-1:0]   b1_t,
    output logic               mul_start,
    output logic               mul_start_t,
    output logic [WIDTH-1:0]   mul_mcand,
    output logic [WIDTH-1:0]   mul_mcand_t,
    output logic [WIDTH-1:0]   mul_mplier,
    output logic [WIDTH-1:0]   mul_mplier_t,
    input  logic               mul_done,
    input  logic               mul_done_t,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic [2*WIDTH-1:0] mul_product_t,
    output logic               ack0,
    output logic               ack0_t,
    output logic               ack1,
    output logic               ack1_t,
    output logic [2*WIDTH-1:0] result,
    output logic [2*WIDTH-1:0] result_t
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    state_t state;
    logic   rr;
    logic   gnt;
    logic   ctl_t;
    logic   pick;
    logic   req_any_t;
    logic   ctl_now;

    // Contended grant goes to the pointer; a lone request wins outright.
    assign pick      = (req0 && req1) ? rr : req1;
    // Both request taints feed the decision, whoever wins.
    assign req_any_t = req0_t | req1_t;
    assign ctl_now   = ctl_t | mul_done_t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr           <= 1'b0;
            gnt          <= 1'b0;
            ctl_t        <= 1'b0;
            mul_start    <= 1'b0;
            mul_start_t  <= 1'b0;
            mul_mcand    <= '0;
            mul_mcand_t  <= '0;
            mul_mplier   <= '0;
            mul_mplier_t <= '0;
            ack0         <= 1'b0;
            ack0_t       <= 1'b0;
            ack1         <= 1'b0;
            ack1_t       <= 1'b0;
            result       <= '0;
            result_t     <= '0;
        end else begin
            mul_start   <= 1'b0;
            mul_start_t <= 1'b0;
            ack0        <= 1'b0;
            ack0_t      <= 1'b0;
            ack1        <= 1'b0;
            ack1_t      <= 1'b0;
            result      <= '0;
            result_t    <= '0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt          <= pick;
                        ctl_t        <= req_any_t;
                        mul_mcand    <= pick ? a1   : a0;
                        mul_mcand_t  <= pick ? a1_t : a0_t;
                        mul_mplier   <= pick ? b1   : b0;
                        mul_mplier_t <= pick ? b1_t : b0_t;
                        mul_start    <= 1'b1;
                        mul_start_t  <= req_any_t;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // The done-taint of the completing cycle also marks the response.
                    ctl_t <= ctl_now;
                    if (mul_done) begin
                        ack0     <= ~gnt;
                        ack0_t   <= ~gnt & ctl_now;
                        ack1     <= gnt;
                        ack1_t   <= gnt & ctl_now;
                        result   <= mul_product;
                        result_t <= mul_product_t | {(2*WIDTH){ctl_now}};
                        state    <= RESP;
                    end
                end
                RESP: begin
                    rr    <= ~gnt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter_taint.sv
// Randomised bench for mult_share_arbiter_taint; the bench also plays the multiplier.
module tb_mult_share_arbiter_taint;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, req0_t, req1_t;
    logic [3:0] a0, b0, a0_t, b0_t, a1, b1, a1_t, b1_t;
    logic       mul_start, mul_start_t;
    logic [3:0] mul_mcand, mul_mcand_t, mul_mplier, mul_mplier_t;
    logic       mul_done, mul_done_t;
    logic [7:0] mul_product, mul_product_t;
    logic       ack0, ack0_t, ack1, ack1_t;
    logic [7:0] result, result_t;

    logic       e_start, e_start_t, e_ack0, e_ack0_t, e_ack1, e_ack1_t;
    logic [3:0] e_mcand, e_mcand_t, e_mplier, e_mplier_t;
    logic [7:0] e_res, e_res_t;
    logic       m_rr;
    bit         chk_en = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    mult_share_arbiter_taint #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .req0_t(req0_t), .req1_t(req1_t),
        .a0(a0), .b0(b0), .a0_t(a0_t), .b0_t(b0_t),
        .a1(a1), .b1(b1), .a1_t(a1_t), .b1_t(b1_t),
        .mul_start(mul_start), .mul_start_t(mul_start_t),
        .mul_mcand(mul_mcand), .mul_mcand_t(mul_mcand_t),
        .mul_mplier(mul_mplier), .mul_mplier_t(mul_mplier_t),
        .mul_done(mul_done), .mul_done_t(mul_done_t),
        .mul_product(mul_product), .mul_product_t(mul_product_t),
        .ack0(ack0), .ack0_t(ack0_t), .ack1(ack1), .ack1_t(ack1_t),
        .result(result), .result_t(result_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("mul_start",    32'(mul_start),    32'(e_start));
            chk("mul_start_t",  32'(mul_start_t),  32'(e_start_t));
            chk("mul_mcand",    32'(mul_mcand),    32'(e_mcand));
            chk("mul_mcand_t",  32'(mul_mcand_t),  32'(e_mcand_t));
            chk("mul_mplier",   32'(mul_mplier),   32'(e_mplier));
            chk("mul_mplier_t", 32'(mul_mplier_t), 32'(e_mplier_t));
            chk("ack0",         32'(ack0),         32'(e_ack0));
            chk("ack0_t",       32'(ack0_t),       32'(e_ack0_t));
            chk("ack1",         32'(ack1),         32'(e_ack1));
            chk("ack1_t",       32'(ack1_t),       32'(e_ack1_t));
            chk("result",       32'(result),       32'(e_res));
            chk("result_t",     32'(result_t),     32'(e_res_t));
        end
    end

    task automatic clear_exp(input bit with_operands);
        e_start = 0; e_start_t = 0;
        e_ack0 = 0; e_ack0_t = 0; e_ack1 = 0; e_ack1_t = 0;
        e_res = 0; e_res_t = 0;
        if (with_operands) begin
            e_mcand = 0; e_mcand_t = 0; e_mplier = 0; e_mplier_t = 0;
        end
    endtask

    task automatic set_req(input logic r0, input logic r1, input logic r0t, input logic r1t);
        req0 = r0; req1 = r1; req0_t = r0t; req1_t = r1t;
    endtask

    task automatic set_ops(input logic [3:0] xa0, input logic [3:0] xb0,
                           input logic [3:0] xa1, input logic [3:0] xb1);
        a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
        a0_t = 0; b0_t = 0; a1_t = 0; b1_t = 0;
    endtask

    task automatic idle(input int n);
        req0 = 0; req1 = 0;
        repeat (n) begin
            mul_done = 1'($urandom);
            @(posedge clk); #1;
        end
        mul_done = 0;
    endtask

    // Called one unit after a rising edge with the DUT idle and requests already driven.
    // dt_mode: 0 no done-taint while waiting, 1 random, 2 taint on the first waiting cycle.
    task automatic run_job(input int wait_cyc, input int dt_mode, input logic [7:0] pt,
                           input logic dt_fin, input bit drop, input int rst_at,
                           output int gid, output logic [7:0] res, output logic [7:0] rest,
                           output logic ackt);
        int         win;
        logic       ctl;
        logic [3:0] ma, mb;
        logic [7:0] prod;
        win  = (req0 && req1) ? int'(m_rr) : (req1 ? 1 : 0);
        ctl  = req0_t | req1_t;
        ma   = win ? a1 : a0;
        mb   = win ? b1 : b0;
        prod = 8'(ma) * 8'(mb);
        @(posedge clk); #1;
        e_start = 1; e_start_t = ctl;
        e_mcand = ma; e_mcand_t = win ? a1_t : a0_t;
        e_mplier = mb; e_mplier_t = win ? b1_t : b0_t;
        // Operands move after the grant; the running job must not notice.
        a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        a0_t = 4'($urandom); b0_t = 4'($urandom); a1_t = 4'($urandom); b1_t = 4'($urandom);
        @(posedge clk); #1;
        e_start = 0; e_start_t = 0;
        for (int i = 0; i < wait_cyc; i++) begin
            mul_done = 0;
            mul_done_t = (dt_mode == 2 && i == 0) || (dt_mode == 1 && $urandom_range(0, 3) == 0);
            mul_product = 8'($urandom); mul_product_t = 8'($urandom);
            if (i == rst_at) begin
                #2 rst = 1;
                #1;
                chk("rst_mul_start", 32'(mul_start), 0);
                chk("rst_ack", 32'({ack0, ack1}), 0);
                chk("rst_result", 32'(result), 0);
                chk("rst_mcand", 32'(mul_mcand), 0);
                clear_exp(1);
                m_rr = 0;
                rst = 0;
                req0 = 0; req1 = 0; mul_done = 0; mul_done_t = 0;
                @(posedge clk); #1;
                gid = -1; res = 0; rest = 0; ackt = 0;
                return;
            end
            ctl |= mul_done_t;
            @(posedge clk); #1;
        end
        if (drop) begin
            if (win == 0) req0 = 0;
            else          req1 = 0;
        end
        mul_done = 1; mul_done_t = dt_fin; mul_product = prod; mul_product_t = pt;
        ctl |= dt_fin;
        @(posedge clk); #1;
        e_ack0 = (win == 0); e_ack0_t = (win == 0) && ctl;
        e_ack1 = (win == 1); e_ack1_t = (win == 1) && ctl;
        e_res = prod; e_res_t = pt | {8{ctl}};
        gid  = ack1 ? 1 : (ack0 ? 0 : -1);
        res  = result; rest = result_t; ackt = ack0_t | ack1_t;
        mul_done = 1'($urandom); mul_done_t = 1'($urandom); mul_product = 8'($urandom);
        m_rr = (win == 0);
        @(posedge clk); #1;
        clear_exp(0);
        mul_done = 0; mul_done_t = 0;
    endtask

    initial begin
        int         g;
        logic [7:0] r, rt;
        logic       at;
        bit         r0, r1;
        rst = 1;
        set_req(0, 0, 0, 0);
        set_ops(0, 0, 0, 0);
        mul_done = 0; mul_done_t = 0; mul_product = 0; mul_product_t = 0;
        clear_exp(1);
        m_rr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        idle(2);

        // Both requesters held from reset: alternate starting with requester 0.
        set_req(1, 1, 0, 0); set_ops(15, 15, 2, 7);
        run_job(2, 0, 8'h00, 0, 0, -1, g, r, rt, at);
        chk("t2_gid_first", 32'(g), 0);
        chk("t2_res_225", 32'(r), 225);
        set_ops(15, 15, 2, 7);
        run_job(1, 0, 8'h00, 0, 0, -1, g, r, rt, at);
        chk("t2_gid_second", 32'(g), 1);
        chk("t2_res_14", 32'(r), 14);
        set_ops(1, 1, 1, 1);
        run_job(0, 0, 8'h00, 0, 0, -1, g, r, rt, at);
        chk("t2_gid_third", 32'(g), 0);
        set_ops(1, 1, 1, 1);
        run_job(0, 0, 8'h00, 0, 0, -1, g, r, rt, at);
        chk("t2_gid_fourth", 32'(g), 1);

        set_req(1, 0, 0, 0); set_ops(3, 5, 9, 9);
        run_job(3, 0, 8'h00, 0, 0, -1, g, r, rt, at);
        chk("t1_gid", 32'(g), 0);
        chk("t1_res_15", 32'(r), 15);
        idle(1);

        // Operand taint only flows through the product taint; request taint floods it.
        set_req(1, 0, 0, 0); set_ops(2, 3, 0, 0); a0_t = 4'b0001;
        run_job(2, 0, 8'h05, 0, 0, -1, g, r, rt, at);
        chk("t3_result_t", 32'(rt), 32'h05);
        chk("t3_ack_t_clean", 32'(at), 0);
        set_req(1, 0, 1, 0); set_ops(2, 3, 0, 0);
        run_job(2, 0, 8'h05, 0, 0, -1, g, r, rt, at);
        chk("t3_result_t_ff", 32'(rt), 32'hFF);
        chk("t3_ack_t", 32'(at), 1);

        set_req(0, 1, 0, 0); set_ops(1, 1, 1, 1);
        run_job(1, 0, 8'h00, 0, 0, -1, g, r, rt, at);
        set_req(1, 1, 0, 1); set_ops(4, 4, 5, 5);
        run_job(1, 0, 8'h00, 0, 0, -1, g, r, rt, at);
        chk("t4_gid", 32'(g), 0);
        chk("t4_ack_t_arb", 32'(at), 1);
        set_req(1, 0, 0, 0); set_ops(6, 7, 0, 0);
        run_job(3, 2, 8'h00, 0, 0, -1, g, r, rt, at);
        chk("t4_done_t_ack_t", 32'(at), 1);
        chk("t4_done_t_result_t", 32'(rt), 32'hFF);

        set_req(0, 1, 0, 0); set_ops(0, 0, 3, 3);
        run_job(2, 0, 8'h00, 0, 1, -1, g, r, rt, at);
        chk("t6_gid_dropped", 32'(g), 1);
        idle(3);

        set_req(1, 0, 0, 0); set_ops(5, 5, 0, 0);
        run_job(4, 0, 8'h00, 0, 0, 1, g, r, rt, at);
        set_req(1, 1, 0, 0); set_ops(8, 9, 10, 11);
        run_job(1, 0, 8'h00, 0, 0, -1, g, r, rt, at);
        chk("t5_gid_after_rst", 32'(g), 0);
        chk("t5_res_72", 32'(r), 72);

        for (int k = 0; k < 60; k++) begin
            r0 = 1'($urandom);
            r1 = r0 ? 1'($urandom) : 1'b1;
            set_req(r0, r1, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
            a0_t = 4'($urandom); b0_t = 4'($urandom); a1_t = 4'($urandom); b1_t = 4'($urandom);
            run_job($urandom_range(0, 5), $urandom_range(0, 1), 8'($urandom),
                    $urandom_range(0, 5) == 0, 1'($urandom), -1, g, r, rt, at);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
